imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN: default 32; immediate/datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter SIGN_EXT: default 1; 1 = sign-extend immediates, 0 = zero-extend (legacy behaviour).
REQ-003 SHALL have port clk: input, 1 bit; the single clock, rising edge.
REQ-004 SHALL have port rst_n: input, 1 bit; asynchronous active-low reset.
REQ-005 SHALL have port in_valid: input, 1 bit; instruction offered.
REQ-006 SHALL have port in_ready: output, 1 bit; block accepts the instruction this cycle.
REQ-007 SHALL have port in_instruction: input, `INST_WIDTH (32); raw instruction.
REQ-008 SHALL have port in_type: input, `INST_TYPE_WIDTH; instruction format.
REQ-009 SHALL have port flush: input, 1 bit; discard all buffered entries.
REQ-010 SHALL have port out_valid: output, 1 bit; result available.
REQ-011 SHALL have port out_ready: input, 1 bit; consumer takes the result.
REQ-012 SHALL have port out_immediate: output, XLEN bits; generated immediate.
REQ-013 SHALL have port out_type: output, `INST_TYPE_WIDTH; format passed through with the result.
REQ-014 SHALL have port out_illegal: output, 1 bit; in_type was not a known format.

Function
REQ-015 A transfer SHALL occur on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-016 Formats SHALL be decoded per RISC-V as follows:
- I: inst[31:20].
- JALR: same as I.
- S: {inst[31:25], inst[11:7]}.
- SB: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- U: {inst[31:12], 12'b0}.
- JAL: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
REQ-017 With SIGN_EXT=1 the immediate SHALL be extended to XLEN from its top bit; with SIGN_EXT=0 it SHALL be zero-extended.
- For U, bit 31 is the sign bit when XLEN=64.
REQ-018 An unknown or R type SHALL produce immediate 0 and out_illegal=1, and SHALL still flow through the pipe.
REQ-019 Latency SHALL be exactly 1 cycle from input transfer to out_valid, and throughput SHALL be 1 per cycle with out_ready held high.
REQ-020 Storage SHALL be a 2-entry skid buffer (output register plus skid register), and in_ready SHALL equal !skid_valid, driven from a register.
REQ-021 On a stall (out_valid && !out_ready), out_immediate/out_type/out_illegal SHALL hold stable; a second accepted entry goes to the skid register; in_ready drops the next cycle.
REQ-022 When the output transfers and the skid register is full, the skid entry SHALL move to the output register in the same edge, and in_ready SHALL rise the next cycle.
REQ-023 Simultaneous input and output transfer with one entry held SHALL keep the occupancy at 1 with the new data in the output register.
REQ-024 Order SHALL be preserved; no loss and no duplication.
REQ-025 flush SHALL synchronously clear both valid flags, and any input offered in the same cycle SHALL be dropped.
- Next cycle: out_valid=0, in_ready=1.
- flush has priority over all transfers.

Reset
REQ-026 rst_n low SHALL immediately set the following to 0 and hold them there until rst_n is released:
- out_valid, skid_valid, out_immediate, out_type, out_illegal.
REQ-027 in_ready SHALL read 1 from the first edge after rst_n deasserts.
REQ-028 Reset mid-stream SHALL drop all held entries, with no partial output.

Structure
REQ-029 Format codes, `INST_TYPE_WIDTH and `INST_WIDTH SHALL live in define.vh, and no new codes SHALL be defined locally.
REQ-030 Decode SHALL be one combinational sub-module, imm_decode (parameters XLEN, SIGN_EXT), instantiated once before the skid buffer.

Verification
REQ-031 I, XLEN=32: 0xFFF00093 SHALL give 0xFFFFFFFF one cycle after accept with SIGN_EXT=1, and 0x00000FFF with SIGN_EXT=0.
REQ-032 SB and JAL, SIGN_EXT=1:
- SB 0xFE000EE3 -> 0xFFFFFFFC.
- JAL 0x0010006F -> 0x00000800.
REQ-033 U: 0x123450B7 SHALL give 0x12345000; with XLEN=64, 0x800000B7 SHALL give 0xFFFFFFFF80000000.
REQ-034 Backpressure: with out_ready=0, three back-to-back inputs SHALL behave as follows:
- Two are accepted, then in_ready=0 and the third is held.
- After out_ready=1, the three emerge in order on consecutive cycles.
REQ-035 Illegal type and flush:
- in_type R SHALL give out_illegal=1 and immediate 0.
- flush with two entries held SHALL give out_valid=0 and in_ready=1 next cycle.
- rst_n pulsed mid-stream SHALL give out_valid=0 immediately.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// Typed views of the shared format codes for the immediate pipe.
package imm_gen_pipe_pkg;
`include "define.vh"

  typedef logic [`INST_WIDTH-1:0]      inst_t;
  typedef logic [`INST_TYPE_WIDTH-1:0] inst_type_t;

  localparam inst_type_t TYPE_R    = `INST_TYPE_R;
  localparam inst_type_t TYPE_I    = `INST_TYPE_I;
  localparam inst_type_t TYPE_S    = `INST_TYPE_S;
  localparam inst_type_t TYPE_SB   = `INST_TYPE_SB;
  localparam inst_type_t TYPE_U    = `INST_TYPE_U;
  localparam inst_type_t TYPE_JAL  = `INST_TYPE_JAL;
  localparam inst_type_t TYPE_JALR = `INST_TYPE_JALR;

  function automatic logic is_i_like(inst_type_t t);
    return (t == TYPE_I) || (t == TYPE_JALR);
  endfunction

endpackage

// File: rtl/define.vh
// Shared instruction-format codes and widths for the immediate generator.
`ifndef IMM_GEN_DEFINE_VH
`define IMM_GEN_DEFINE_VH

`define INST_WIDTH      32
`define INST_TYPE_WIDTH 3

`define INST_TYPE_R     3'd0
`define INST_TYPE_I     3'd1
`define INST_TYPE_S     3'd2
`define INST_TYPE_SB    3'd3
`define INST_TYPE_U     3'd4
`define INST_TYPE_JAL   3'd5
`define INST_TYPE_JALR  3'd6

`endif

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RISC-V immediate decode with sign or zero extension.
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit SIGN_EXT = 1'b1
) (
  input  inst_t            inst,
  input  inst_type_t       typ,
  output logic [XLEN-1:0]  imm,
  output logic             illegal
);

  logic [31:0] raw;
  logic [31:0] msk;
  logic        ext;
  logic        unused_opcode;

  assign unused_opcode = ^inst[6:0];

  // every format keeps its sign in inst[31]; msk covers bits above the field
  always_comb begin
    raw     = '0;
    msk     = '0;
    illegal = 1'b0;
    unique case (1'b1)
      is_i_like(typ): begin
        raw = {20'b0, inst[31:20]};
        msk = 32'hFFFF_F000;
      end
      (typ == TYPE_S): begin
        raw = {20'b0, inst[31:25], inst[11:7]};
        msk = 32'hFFFF_F000;
      end
      (typ == TYPE_SB): begin
        raw = {19'b0, inst[31], inst[7],
               inst[30:25], inst[11:8], 1'b0};
        msk = 32'hFFFF_E000;
      end
      (typ == TYPE_U): begin
        raw = {inst[31:12], 12'b0};
        msk = 32'h0;
      end
      (typ == TYPE_JAL): begin
        raw = {11'b0, inst[31], inst[19:12],
               inst[20], inst[30:21], 1'b0};
        msk = 32'hFFE0_0000;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign ext = SIGN_EXT && inst[31] && !illegal;

  assign imm = XLEN'({{32{ext}}, raw | (ext ? msk : 32'h0)});

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator: one decode stage feeding a 2-entry skid buffer.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit SIGN_EXT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  inst_t           in_instruction,
  input  inst_type_t      in_type,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_immediate,
  output inst_type_t      out_type,
  output logic            out_illegal
);

  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;

  logic            skid_valid;
  logic [XLEN-1:0] skid_imm;
  inst_type_t      skid_type;
  logic            skid_ill;
  logic            rdy_q;

  logic in_fire;
  logic out_fire;
  logic ov_nxt;
  logic sv_nxt;
  logic ld_out;
  logic mv_skid;
  logic ld_skid;

  imm_decode #(
    .XLEN     (XLEN),
    .SIGN_EXT (SIGN_EXT)
  ) u_dec (
    .inst    (in_instruction),
    .typ     (in_type),
    .imm     (dec_imm),
    .illegal (dec_ill)
  );

  assign in_ready = rdy_q;
  assign in_fire  = in_valid && rdy_q;
  assign out_fire = out_valid && out_ready;

  // skid_valid implies out_valid, so the first branch with skid_valid is a pop
  always_comb begin
    ov_nxt  = out_valid;
    sv_nxt  = skid_valid;
    ld_out  = 1'b0;
    mv_skid = 1'b0;
    ld_skid = 1'b0;
    if (flush) begin
      ov_nxt = 1'b0;
      sv_nxt = 1'b0;
    end else if (!out_valid || out_fire) begin
      if (skid_valid) begin
        mv_skid = 1'b1;
        sv_nxt  = 1'b0;
        ov_nxt  = 1'b1;
      end else if (in_fire) begin
        ld_out = 1'b1;
        ov_nxt = 1'b1;
      end else begin
        ov_nxt = 1'b0;
      end
    end else if (in_fire) begin
      ld_skid = 1'b1;
      sv_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_immediate <= '0;
      out_type      <= '0;
      out_illegal   <= 1'b0;
      skid_valid    <= 1'b0;
      skid_imm      <= '0;
      skid_type     <= '0;
      skid_ill      <= 1'b0;
      rdy_q         <= 1'b0;
    end else begin
      out_valid  <= ov_nxt;
      skid_valid <= sv_nxt;
      rdy_q      <= !sv_nxt;
      if (ld_out) begin
        out_immediate <= dec_imm;
        out_type      <= in_type;
        out_illegal   <= dec_ill;
      end else if (mv_skid) begin
        out_immediate <= skid_imm;
        out_type      <= skid_type;
        out_illegal   <= skid_ill;
      end
      if (ld_skid) begin
        skid_imm  <= dec_imm;
        skid_type <= in_type;
        skid_ill  <= dec_ill;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three parameterisations against a queue model.
module tb_imm_gen_pipe;
  import imm_gen_pipe_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  inst_t      in_instruction;
  inst_type_t in_type;
  logic       flush;
  logic       out_ready;

  logic        rdy_s32, ov_s32, ill_s32;
  logic [31:0] imm_s32;
  inst_type_t  typ_s32;
  logic        rdy_z32, ov_z32, ill_z32;
  logic [31:0] imm_z32;
  inst_type_t  typ_z32;
  logic        rdy_s64, ov_s64, ill_s64;
  logic [63:0] imm_s64;
  inst_type_t  typ_s64;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] inst;
    inst_type_t  t;
  } ent_t;

  ent_t q[$];
  bit   armed = 0;

  imm_gen_pipe #(.XLEN(32), .SIGN_EXT(1'b1)) u_s32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s32),
    .in_instruction(in_instruction), .in_type(in_type), .flush(flush),
    .out_valid(ov_s32), .out_ready(out_ready), .out_immediate(imm_s32),
    .out_type(typ_s32), .out_illegal(ill_s32));

  imm_gen_pipe #(.XLEN(32), .SIGN_EXT(1'b0)) u_z32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_z32),
    .in_instruction(in_instruction), .in_type(in_type), .flush(flush),
    .out_valid(ov_z32), .out_ready(out_ready), .out_immediate(imm_z32),
    .out_type(typ_z32), .out_illegal(ill_z32));

  imm_gen_pipe #(.XLEN(64), .SIGN_EXT(1'b1)) u_s64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s64),
    .in_instruction(in_instruction), .in_type(in_type), .flush(flush),
    .out_valid(ov_s64), .out_ready(out_ready), .out_immediate(imm_s64),
    .out_type(typ_s64), .out_illegal(ill_s64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit known(inst_type_t t);
    return t inside {TYPE_I, TYPE_JALR, TYPE_S, TYPE_SB, TYPE_U, TYPE_JAL};
  endfunction

  // field value and width, then two's-complement extension by arithmetic
  function automatic logic [63:0] ref_imm(logic [31:0] i, inst_type_t t,
                                          int xlen, bit sext);
    longint f;
    longint v;
    int     w;
    f = 0;
    w = 1;
    if (t == TYPE_I || t == TYPE_JALR) begin
      f = longint'(i[31:20]); w = 12;
    end else if (t == TYPE_S) begin
      f = longint'({i[31:25], i[11:7]}); w = 12;
    end else if (t == TYPE_SB) begin
      f = longint'({i[31], i[7], i[30:25], i[11:8], 1'b0}); w = 13;
    end else if (t == TYPE_U) begin
      f = longint'(i[31:12]) * 4096; w = 32;
    end else if (t == TYPE_JAL) begin
      f = longint'({i[31], i[19:12], i[20], i[30:21], 1'b0}); w = 21;
    end else begin
      return 64'h0;
    end
    v = f;
    if (sext && ((f >> (w - 1)) & 1) == 1) v = f - (longint'(1) << w);
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return 64'(v);
  endfunction

  task automatic check_dut(string n, logic rdy, logic ov, logic [63:0] imm,
                           inst_type_t typ, logic ill, int xlen, bit sext);
    if (!rst_n) begin
      chk({n, "_rst_ov"}, 64'(ov), 64'h0);
      chk({n, "_rst_imm"}, imm, 64'h0);
      chk({n, "_rst_typ"}, 64'(typ), 64'h0);
      chk({n, "_rst_ill"}, 64'(ill), 64'h0);
    end else begin
      chk({n, "_rdy"}, 64'(rdy), 64'(armed && q.size() < 2));
      chk({n, "_ov"}, 64'(ov), 64'(q.size() > 0));
      if (q.size() > 0) begin
        chk({n, "_imm"}, imm, ref_imm(q[0].inst, q[0].t, xlen, sext));
        chk({n, "_typ"}, 64'(typ), 64'(q[0].t));
        chk({n, "_ill"}, 64'(ill), 64'(!known(q[0].t)));
      end
    end
  endtask

  // reference occupancy: in_ready is "fewer than two held", one edge after reset
  initial forever begin
    bit exp_rdy, ifire, ofire;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      armed = 0;
    end else begin
      exp_rdy = armed && q.size() < 2;
      ofire   = q.size() > 0 && out_ready;
      ifire   = in_valid && exp_rdy;
      if (flush) begin
        q.delete();
      end else begin
        if (ofire) void'(q.pop_front());
        if (ifire) q.push_back('{in_instruction, in_type});
      end
      armed = 1;
    end
  end

  always @(negedge clk) begin
    check_dut("s32", rdy_s32, ov_s32, {32'h0, imm_s32}, typ_s32, ill_s32, 32, 1'b1);
    check_dut("z32", rdy_z32, ov_z32, {32'h0, imm_z32}, typ_z32, ill_z32, 32, 1'b0);
    check_dut("s64", rdy_s64, ov_s64, imm_s64, typ_s64, ill_s64, 64, 1'b1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [31:0] i, inst_type_t t);
    in_valid       = 1'b1;
    in_instruction = i;
    in_type        = t;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b1;
    in_valid       = 1'b0;
    in_instruction = '0;
    in_type        = TYPE_R;
    flush          = 1'b0;
    out_ready      = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_out_valid", 64'(ov_s32), 64'h0);
    chk("reset_out_imm", imm_s64, 64'h0);
    #19 rst_n = 1'b1;
    tick();
    chk("ready_after_reset", 64'(rdy_s32), 64'h1);

    send(32'hFFF0_0093, TYPE_I);
    chk("i_sext32", 64'(imm_s32), 64'hFFFF_FFFF);
    chk("i_zext32", 64'(imm_z32), 64'h0000_0FFF);
    chk("i_sext64", imm_s64, 64'hFFFF_FFFF_FFFF_FFFF);
    send(32'hFE00_0EE3, TYPE_SB);
    chk("sb_neg", 64'(imm_s32), 64'hFFFF_FFFC);
    send(32'h0010_006F, TYPE_JAL);
    chk("jal_pos", 64'(imm_s32), 64'h0000_0800);
    send(32'h1234_50B7, TYPE_U);
    chk("u_32", 64'(imm_s32), 64'h1234_5000);
    send(32'h8000_00B7, TYPE_U);
    chk("u_64_sign", imm_s64, 64'hFFFF_FFFF_8000_0000);
    chk("u_32_top", 64'(imm_s32), 64'h8000_0000);
    send(32'hFFFF_FFB3, TYPE_R);
    chk("r_illegal", 64'(ill_s32), 64'h1);
    chk("r_imm_zero", 64'(imm_s32), 64'h0);
    tick();

    out_ready = 1'b0;
    in_valid = 1'b1; in_type = TYPE_I;
    in_instruction = 32'h0010_0093;
    tick();
    in_instruction = 32'h0020_0093;
    tick();
    chk("bp_ready_low", 64'(rdy_s32), 64'h0);
    in_instruction = 32'h0030_0093;
    tick();
    chk("bp_third_held", 64'(rdy_s32), 64'h0);
    chk("bp_out_stable", 64'(imm_s32), 64'h1);
    out_ready = 1'b1;
    tick();
    chk("bp_second", 64'(imm_s32), 64'h2);
    tick();
    in_valid = 1'b0;
    chk("bp_third", 64'(imm_s32), 64'h3);
    tick();
    chk("bp_drained", 64'(ov_s32), 64'h0);

    out_ready = 1'b0;
    send(32'h0050_0093, TYPE_I);
    send(32'h0060_0093, TYPE_I);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush2_out_valid", 64'(ov_s32), 64'h0);
    chk("flush2_ready", 64'(rdy_s32), 64'h1);
    send(32'h0070_0093, TYPE_I);
    in_valid = 1'b1; flush = 1'b1;
    in_instruction = 32'h0080_0093;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush1_out_valid", 64'(ov_z32), 64'h0);
    tick();
    chk("flush_drop_input", 64'(ov_z32), 64'h0);
    out_ready = 1'b1;

    out_ready = 1'b0;
    send(32'h0090_0093, TYPE_I);
    send(32'h00A0_0093, TYPE_I);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(ov_s64), 64'h0);
    chk("midrst_imm", imm_s64, 64'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("midrst_ready", 64'(rdy_s32), 64'h1);
    chk("midrst_empty", 64'(ov_s32), 64'h0);
    out_ready = 1'b1;

    for (int c = 0; c < 2000; c++) begin
      in_valid       = ($urandom % 4) != 0;
      in_instruction = $urandom;
      in_type        = inst_type_t'($urandom_range(0, 7));
      out_ready      = ($urandom % 4) != 0;
      flush          = ($urandom % 40) == 0;
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
